// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity encodings and majority vote for the UART receiver
// Contents: uart_state_t (receiver FSM states), PARITY_* encodings, maj3() 2-of-3 vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one pulse every DIV clocks
// Ports: clk, rst (sync, active-high), restart (realign divider to this cycle), tick (1-cycle pulse).
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // No tick on the realign cycle: the first tick of a new frame lands DIV clocks later.
  assign tick = (cnt == CNT_MAX) && !restart;

endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with majority vote and valid/ready output
// Ports: clk, rst (sync, active-high), rx_i (async line, idle high),
//        rx_data/rx_valid/rx_ready (held word + handshake), parity_err/frame_err (qualified by rx_valid),
//        overrun_err (1-cycle pulse when a finished frame is dropped), busy (FSM not idle).
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_param_err
    $error("uart_rx_ovs: illegal DATA_BITS/PARITY/STOP_BITS/OVERSAMPLE");
  end

  localparam int OCW = $clog2(OVERSAMPLE);
  localparam logic [OCW-1:0] OS_LAST = OCW'(OVERSAMPLE - 1);
  localparam logic [OCW-1:0] V0      = OCW'(OVERSAMPLE / 2 - 1);
  localparam logic [OCW-1:0] V1      = OCW'(OVERSAMPLE / 2);
  localparam logic [OCW-1:0] V2      = OCW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           ODD_PAR   = (PARITY == PARITY_ODD);

  logic rx_meta, rx_sync, rx_prev;
  logic fall;
  uart_state_t state, next_state;
  logic tick, restart, frame_done, counting, vote_tick, bit_end, vote, ferr_now;
  logic [OCW-1:0]       os_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 perr_r, ferr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign counting  = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
  assign vote_tick = tick && counting && (os_cnt == V2);
  assign bit_end   = tick && counting && (os_cnt == OS_LAST);
  // The third sample is the live line value; the first two were captured on earlier ticks.
  assign vote      = maj3(samp[0], samp[1], rx_sync);
  assign ferr_now  = ferr_r | ~vote;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          next_state = ST_START;
          restart    = 1'b1;
        end
      end
      ST_START: begin
        if (vote_tick && vote) next_state = ST_IDLE;
        else if (bit_end)      next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == DATA_LAST)
          next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) next_state = ST_STOP;
      end
      ST_STOP: begin
        // Frame ends at the last stop vote, half a bit early, so the next start edge is never missed.
        if (vote_tick && stop_cnt == STOP_LAST) begin
          frame_done = 1'b1;
          next_state = ferr_now ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      os_cnt   <= '0;
      samp     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else if (tick && counting) begin
      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      if (os_cnt == V0) samp[0] <= rx_sync;
      if (os_cnt == V1) samp[1] <= rx_sync;
      if (os_cnt == V2) begin
        case (state)
          ST_DATA:   shreg  <= {vote, shreg[DATA_BITS-1:1]};
          ST_PARITY: perr_r <= ((^shreg) ^ ODD_PAR) != vote;
          ST_STOP:   ferr_r <= ferr_now;
          default:   ;
        endcase
      end
      if (os_cnt == OS_LAST) begin
        if (state == ST_DATA) bit_cnt  <= bit_cnt + 4'd1;
        if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr_r;
          frame_err  <= ferr_now;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - self-checking bench for uart_rx_ovs (8N1 instance and even-parity instance)
module tb_uart_rx_ovs;

  localparam int DIV = 27;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic line_a = 1'b1, ready_a = 1'b1;
  logic [7:0] data_a;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;

  logic line_b = 1'b1, ready_b = 1'b1;
  logic [7:0] data_b;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;

  uart_rx_ovs dut_a (
    .clk(clk), .rst(rst), .rx_i(line_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_ovs #(.PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .rx_i(line_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b), .busy(busy_b)
  );

  word_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  int ovr_cnt_a = 0, valid_cycles_a = 0;
  int n_cmp = 0, n_fail = 0;

  always @(negedge clk) begin
    if (valid_a && ready_a) obs_a.push_back(word_t'({data_a, perr_a, ferr_a}));
    if (valid_b && ready_b) obs_b.push_back(word_t'({data_b, perr_b, ferr_b}));
    if (ovr_a)   ovr_cnt_a++;
    if (valid_a) valid_cycles_a++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word content follows from the bits put on the line.
  function automatic word_t model(input logic [7:0] d, input int par_mode,
                                  input logic pbit, input logic stop_v);
    word_t w;
    int ones;
    ones   = $countones(d) + int'(pbit);
    w.data = d;
    w.ferr = !stop_v;
    case (par_mode)
      1:       w.perr = (ones % 2) != 1;
      2:       w.perr = (ones % 2) != 0;
      default: w.perr = 1'b0;
    endcase
    return w;
  endfunction

  task automatic drive(input int which, input logic v, input int nclk);
    if (which == 0) line_a = v;
    else            line_b = v;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop_v);
    drive(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(which, d[i], BIT);
    if (use_par) drive(which, pbit, BIT);
    drive(which, stop_v, BIT);
  endtask

  task automatic check_words(input string tag, input int which);
    word_t o, e;
    int no, ne;
    no = (which == 0) ? obs_a.size() : obs_b.size();
    ne = (which == 0) ? exp_a.size() : exp_b.size();
    chk({tag, ".count"}, no, ne);
    for (int i = 0; i < ((no < ne) ? no : ne); i++) begin
      if (which == 0) begin o = obs_a.pop_front(); e = exp_a.pop_front(); end
      else            begin o = obs_b.pop_front(); e = exp_b.pop_front(); end
      chk({tag, ".data"}, o.data, e.data);
      chk({tag, ".perr"}, o.perr, e.perr);
      chk({tag, ".ferr"}, o.ferr, e.ferr);
    end
    if (which == 0) begin obs_a.delete(); exp_a.delete(); end
    else            begin obs_b.delete(); exp_b.delete(); end
  endtask

  initial begin
    int vc0, ov0;
    logic found;
    logic [7:0] d;
    logic sv, pb;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.data",  data_a, 0);
    chk("rst.valid", valid_a, 0);
    chk("rst.perr",  perr_a, 0);
    chk("rst.ferr",  ferr_a, 0);
    chk("rst.ovr",   ovr_a, 0);
    chk("rst.busy",  busy_a, 0);
    chk("rst.valid_b", valid_b, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // 8N1 0xA5 with ready held high
    vc0 = valid_cycles_a;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    exp_a.push_back(model(8'hA5, 0, 1'b0, 1'b1));
    drive(0, 1'b1, BIT);
    check_words("a5", 0);
    chk("a5.valid_cycles", valid_cycles_a - vc0, 1);

    // short low glitch on idle line
    drive(0, 1'b0, 4 * DIV);
    line_a = 1'b1;
    @(negedge clk);
    chk("glitch.busy_seen", busy_a, 1);
    found = 1'b0;
    for (int i = 0; i < BIT - 4 * DIV; i++) begin
      @(negedge clk);
      if (!busy_a) begin found = 1'b1; break; end
    end
    chk("glitch.busy_clears", found, 1);
    @(posedge clk); #1;
    drive(0, 1'b1, BIT);
    check_words("glitch", 0);

    // break: 0x00 with stop low, line held low 3 more bit times
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_a.push_back(model(8'h00, 0, 1'b0, 1'b0));
    drive(0, 1'b0, 3 * BIT);
    check_words("break", 0);
    @(negedge clk);
    chk("break.wait_high_busy", busy_a, 1);
    @(posedge clk); #1;
    drive(0, 1'b1, BIT);
    @(negedge clk);
    chk("break.idle_after_high", busy_a, 0);
    check_words("break.no_second", 0);
    @(posedge clk); #1;

    // overrun: two frames with ready low
    ready_a = 1'b0;
    ov0 = ovr_cnt_a;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    @(negedge clk);
    chk("ovr.pulses", ovr_cnt_a - ov0, 1);
    chk("ovr.held_data", data_a, 8'h11);
    chk("ovr.held_valid", valid_a, 1);
    check_words("ovr.held", 0);
    @(posedge clk); #1 ready_a = 1'b1;
    exp_a.push_back(model(8'h11, 0, 1'b0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    chk("ovr.valid_drops", valid_a, 0);
    check_words("ovr.release", 0);
    @(posedge clk); #1;

    // reset in the middle of 0x5A (bits 0..2 sent, abort during bit 3 which is high)
    d = 8'h5A;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(0, d[i], BIT);
    drive(0, 1'b1, BIT / 2);
    rst = 1'b1;
    drive(0, 1'b1, 4);
    @(negedge clk);
    chk("rstmid.busy", busy_a, 0);
    chk("rstmid.valid", valid_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1'b1, BIT);
    check_words("rstmid.nothing", 0);
    send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
    exp_a.push_back(model(8'h96, 0, 1'b0, 1'b1));
    drive(0, 1'b1, BIT);
    check_words("rstmid.after", 0);

    // random 8N1 frames, occasional bad stop bit
    for (int k = 0; k < 4; k++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 1'b0, 1'b0, sv);
      exp_a.push_back(model(d, 0, 1'b0, sv));
      drive(0, 1'b1, BIT);
    end
    check_words("rand_a", 0);

    // even parity instance: 0x3C has an even number of ones
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    exp_b.push_back(model(8'h3C, 2, 1'b1, 1'b1));
    drive(1, 1'b1, BIT);
    check_words("par.bad", 1);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    exp_b.push_back(model(8'h3C, 2, 1'b0, 1'b1));
    drive(1, 1'b1, BIT);
    check_words("par.good", 1);

    for (int k = 0; k < 2; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(1, d, 1'b1, pb, 1'b1);
      exp_b.push_back(model(d, 2, pb, 1'b1));
      drive(1, 1'b1, BIT);
    end
    check_words("rand_b", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
